// File: rtl/gpio_dm_seq.sv
// Drive-mode shadow register and serial clock/data/load sequencer for the GPIO pad chain.
// Optional macro GPIO_DM_SANITIZE_EN coerces unsupported DM codes to 3'b001 on write.
module gpio_dm_seq #(
    parameter int NUM_PADS = 8,
    parameter int CLK_DIV  = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cfg_wr_en,
    input  logic [5:0] cfg_wr_idx,
    input  logic [2:0] cfg_wr_dm,
    output logic       cfg_wr_err,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       serial_clock,
    output logic       serial_data,
    output logic       serial_load
);

    localparam int         NB       = NUM_PADS * 3;
    localparam logic [5:0] NP6      = 6'(NUM_PADS);
    localparam logic [7:0] LAST_BIT = 8'(NB - 1);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_t;

    state_t          state;
    logic [NB-1:0]   shadow;
    logic [NB-1:0]   shadow_nxt;
    logic [NB-1:0]   shreg;
    logic [7:0]      bit_cnt;
    logic [3:0]      div_cnt;
    logic [2:0]      wr_val;

    function automatic logic [2:0] sanitize(input logic [2:0] dm);
`ifdef GPIO_DM_SANITIZE_EN
        case (dm)
            3'b001, 3'b010, 3'b011, 3'b110: return dm;
            default:                        return 3'b001;
        endcase
`else
        return dm;
`endif
    endfunction

    function automatic logic dm_bad(input logic [2:0] dm);
        return sanitize(dm) != dm;
    endfunction

    // Shadow as it will be after this edge, so a same-cycle start snapshots the write.
    always_comb begin
        wr_val     = sanitize(cfg_wr_dm);
        shadow_nxt = shadow;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (cfg_wr_en && cfg_wr_idx == 6'(p)) begin
                shadow_nxt[3*p +: 3] = wr_val;
            end
        end
    end

    // Serial data comes straight from the shift register MSB; zeros shift in behind it.
    assign serial_data = shreg[NB-1];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            shadow       <= {NUM_PADS{3'b001}};
            shreg        <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_clock <= 1'b0;
            serial_load  <= 1'b0;
            cfg_wr_err   <= 1'b0;
        end else begin
            shadow     <= shadow_nxt;
            cfg_wr_err <= cfg_wr_en && ((cfg_wr_idx >= NP6) || dm_bad(cfg_wr_dm));
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SHIFT;
                        shreg        <= shadow_nxt;
                        bit_cnt      <= '0;
                        div_cnt      <= '0;
                        busy         <= 1'b1;
                        serial_clock <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!serial_clock) begin
                            serial_clock <= 1'b1;
                        end else begin
                            // End of a bit: the final shift empties the register for LOAD.
                            serial_clock <= 1'b0;
                            shreg        <= shreg << 1;
                            if (bit_cnt == LAST_BIT) begin
                                state       <= LOAD;
                                serial_load <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 8'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                LOAD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt     <= '0;
                        serial_load <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
